// File: rtl/tube_sync_chan.sv
// ---------------------------------------------------------------------------
// tube_sync_chan
//
// Single-clock, bidirectional mailbox between a host processor and a
// parasite (second) processor. Two independent FIFOs carry data:
//   HP : host pushes, parasite pops
//   PH : parasite pushes, host pops
// The host owns three control flags (Q, I, V) and can flush both FIFOs
// or clear their sticky overflow flags. Each side sees its own status
// register and gets its own registered, active-low interrupt.
//
// Ports
//   h_phi2   in   1      sole clock, all state updates on rising edge
//   h_rst_b  in   1      synchronous active-low reset
//   h_cs     in   1      host select
//   h_we     in   1      host write (1) / read (0)
//   h_addr   in   1      0 = status/control, 1 = data
//   h_wdata  in   WIDTH  host write data
//   h_rdata  out  WIDTH  host read data, registered
//   p_cs     in   1      parasite select
//   p_we     in   1      parasite write (1) / read (0)
//   p_addr   in   1      0 = status, 1 = data
//   p_wdata  in   WIDTH  parasite write data
//   p_rdata  out  WIDTH  parasite read data, registered
//   h_irq_b  out  1      host interrupt, active low
//   p_irq_b  out  1      parasite interrupt, active low
//
// Control word written by the host at addr 0:
//   bit 0 Q mask, bit 1 I mask, bit 2 V mask -> selected flags take bit 7
//   bit 3 T       -> flush both FIFOs and clear both OVF flags
//   bit 4 + bit7=0 -> clear both OVF flags only
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// tube_sync_fifo
//
// DEPTH x WIDTH circular FIFO with an occupancy counter and a sticky
// overflow flag. Pointers wrap naturally because DEPTH is a power of two.
//
// Ports
//   h_phi2   in   1      clock
//   h_rst_b  in   1      synchronous active-low reset
//   flush    in   1      empty the FIFO, clear OVF, discard same-edge ops
//   ovf_clr  in   1      clear the sticky OVF flag
//   push     in   1      write request
//   pop      in   1      read-and-remove request
//   wdata    in   WIDTH  data to push
//   head     out  WIDTH  word at the read pointer (stale when empty)
//   count    out  CW     occupancy, 0..DEPTH
//   full     out  1      count == DEPTH
//   empty    out  1      count == 0
//   ovf      out  1      sticky: a push was dropped because FIFO was full
// ---------------------------------------------------------------------------
module tube_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     h_phi2,
    input  logic                     h_rst_b,
    input  logic                     flush,
    input  logic                     ovf_clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic             ovf_set;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop of an empty FIFO is a no-op. A push into a full FIFO only
    // lands if the same edge frees a slot; otherwise it is dropped and
    // flagged. A flush discards everything in flight.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & (~full | do_pop) & ~flush;
    assign ovf_set = push & full & ~pop & ~flush;

    assign head = mem[rd_ptr];

    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples pre-edge values, independent of block order.
    always_ff @(posedge h_phi2) begin
        if (!h_rst_b || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (do_pop && !do_push) begin
                count <= count - CW'(1);
            end
            // A new overflow on the same edge as a clear wins, so a
            // dropped word is never silently lost.
            ovf <= (ovf & ~ovf_clr) | ovf_set;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and the
    // counter define which words are valid, so stale contents are never
    // observed and the array can map onto plain RAM.
    always_ff @(posedge h_phi2) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

module tube_sync_chan #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int THRESH = 2
) (
    input  logic             h_phi2,
    input  logic             h_rst_b,
    input  logic             h_cs,
    input  logic             h_we,
    input  logic             h_addr,
    input  logic [WIDTH-1:0] h_wdata,
    output logic [WIDTH-1:0] h_rdata,
    input  logic             p_cs,
    input  logic             p_we,
    input  logic             p_addr,
    input  logic [WIDTH-1:0] p_wdata,
    output logic [WIDTH-1:0] p_rdata,
    output logic             h_irq_b,
    output logic             p_irq_b
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

    // Control word bit positions.
    localparam int CTL_Q   = 0;
    localparam int CTL_I   = 1;
    localparam int CTL_V   = 2;
    localparam int CTL_T   = 3;
    localparam int CTL_CLR = 4;
    localparam int CTL_VAL = 7;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    logic h_push;      // host data write  -> HP push
    logic h_pop;       // host data read   -> PH pop
    logic h_rd;        // any host read
    logic h_ctl_wr;    // host control write
    logic p_push;      // parasite data write -> PH push
    logic p_pop;       // parasite data read  -> HP pop
    logic p_rd;        // any parasite read

    assign h_push   = h_cs &  h_we &  h_addr;
    assign h_pop    = h_cs & ~h_we &  h_addr;
    assign h_rd     = h_cs & ~h_we;
    assign h_ctl_wr = h_cs &  h_we & ~h_addr;
    assign p_push   = p_cs &  p_we &  p_addr;
    assign p_pop    = p_cs & ~p_we &  p_addr;
    assign p_rd     = p_cs & ~p_we;
    // Parasite writes to addr 0 have no decode and are therefore ignored.

    logic flush;       // T bit: empty both FIFOs
    logic ovf_clr;     // clear both sticky OVF flags

    assign flush   = h_ctl_wr & h_wdata[CTL_T];
    assign ovf_clr = h_ctl_wr & h_wdata[CTL_CLR] & ~h_wdata[CTL_VAL];

    // ------------------------------------------------------------------
    // FIFOs
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] hp_head;
    logic [CW-1:0]    hp_count;
    logic             hp_full;
    logic             hp_empty;
    logic             hp_ovf;

    logic [WIDTH-1:0] ph_head;
    logic [CW-1:0]    ph_count;
    logic             ph_full;
    logic             ph_empty;
    logic             ph_ovf;

    tube_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_hp (
        .h_phi2  (h_phi2),
        .h_rst_b (h_rst_b),
        .flush   (flush),
        .ovf_clr (ovf_clr),
        .push    (h_push),
        .pop     (p_pop),
        .wdata   (h_wdata),
        .head    (hp_head),
        .count   (hp_count),
        .full    (hp_full),
        .empty   (hp_empty),
        .ovf     (hp_ovf)
    );

    tube_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_ph (
        .h_phi2  (h_phi2),
        .h_rst_b (h_rst_b),
        .flush   (flush),
        .ovf_clr (ovf_clr),
        .push    (p_push),
        .pop     (h_pop),
        .wdata   (p_wdata),
        .head    (ph_head),
        .count   (ph_count),
        .full    (ph_full),
        .empty   (ph_empty),
        .ovf     (ph_ovf)
    );

    // ------------------------------------------------------------------
    // Host-owned control flags
    // ------------------------------------------------------------------
    logic flag_q;
    logic flag_i;
    logic flag_v;

    // Each mask bit selects one flag; the selected flags all take the
    // value in bit 7, so one write can set or clear any subset.
    always_ff @(posedge h_phi2) begin
        if (!h_rst_b) begin
            flag_q <= 1'b0;
            flag_i <= 1'b0;
            flag_v <= 1'b0;
        end else if (h_ctl_wr) begin
            if (h_wdata[CTL_Q]) flag_q <= h_wdata[CTL_VAL];
            if (h_wdata[CTL_I]) flag_i <= h_wdata[CTL_VAL];
            if (h_wdata[CTL_V]) flag_v <= h_wdata[CTL_VAL];
        end
    end

    // ------------------------------------------------------------------
    // Data-available and status
    // ------------------------------------------------------------------
    logic             avail_hp;
    logic             avail_ph;
    logic [WIDTH-1:0] h_status;
    logic [WIDTH-1:0] p_status;

    // In threshold mode the reader is only told about data once a batch
    // of THRESH words has built up; otherwise any word counts.
    assign avail_hp = flag_v ? (hp_count >= THRESH_C) : !hp_empty;
    assign avail_ph = flag_v ? (ph_count >= THRESH_C) : !ph_empty;

    // NOTE: every variable assigned in always_comb gets a full default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        h_status      = '0;
        p_status      = '0;
        h_status[7:0] = {avail_ph, ~ph_full, hp_ovf, 2'b00, flag_v, flag_i, flag_q};
        p_status[7:0] = {avail_hp, ~hp_full, ph_ovf, 2'b00, flag_v, flag_i, flag_q};
    end

    // ------------------------------------------------------------------
    // Registered read data. A data read of an empty FIFO returns all
    // ones. Read data only changes on a read access and otherwise holds.
    // ------------------------------------------------------------------
    always_ff @(posedge h_phi2) begin
        if (!h_rst_b) begin
            h_rdata <= '0;
        end else if (h_rd) begin
            if (h_addr) begin
                h_rdata <= ph_empty ? '1 : ph_head;
            end else begin
                h_rdata <= h_status;
            end
        end
    end

    always_ff @(posedge h_phi2) begin
        if (!h_rst_b) begin
            p_rdata <= '0;
        end else if (p_rd) begin
            if (p_addr) begin
                p_rdata <= hp_empty ? '1 : hp_head;
            end else begin
                p_rdata <= p_status;
            end
        end
    end

    // ------------------------------------------------------------------
    // Interrupts: registered from pre-edge state, so they assert one
    // cycle after the enabling condition becomes true.
    // ------------------------------------------------------------------
    always_ff @(posedge h_phi2) begin
        if (!h_rst_b) begin
            h_irq_b <= 1'b1;
            p_irq_b <= 1'b1;
        end else begin
            h_irq_b <= ~(flag_q & avail_ph);
            p_irq_b <= ~(flag_i & avail_hp);
        end
    end

endmodule

// File: tb/tb_tube_sync_chan.sv
module tb_tube_sync_chan;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int TH = 2;

    logic         h_phi2 = 1'b0;
    logic         h_rst_b = 1'b0;
    logic         h_cs = 1'b0, h_we = 1'b0, h_addr = 1'b0;
    logic [W-1:0] h_wdata = '0;
    logic [W-1:0] h_rdata;
    logic         p_cs = 1'b0, p_we = 1'b0, p_addr = 1'b0;
    logic [W-1:0] p_wdata = '0;
    logic [W-1:0] p_rdata;
    logic         h_irq_b;
    logic         p_irq_b;

    always #5 h_phi2 = ~h_phi2;

    tube_sync_chan #(
        .WIDTH  (W),
        .DEPTH  (D),
        .THRESH (TH)
    ) dut (
        .h_phi2  (h_phi2),
        .h_rst_b (h_rst_b),
        .h_cs    (h_cs),
        .h_we    (h_we),
        .h_addr  (h_addr),
        .h_wdata (h_wdata),
        .h_rdata (h_rdata),
        .p_cs    (p_cs),
        .p_we    (p_we),
        .p_addr  (p_addr),
        .p_wdata (p_wdata),
        .p_rdata (p_rdata),
        .h_irq_b (h_irq_b),
        .p_irq_b (p_irq_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: FIFO contents as queues, flags as bits.
    logic [7:0] hp_q[$];
    logic [7:0] ph_q[$];
    logic [7:0] exp_h_q[$];   // scoreboard of expected host reads
    logic [7:0] exp_p_q[$];   // scoreboard of expected parasite reads
    logic       m_q, m_i, m_v, m_ovf_hp, m_ovf_ph;
    logic       m_h_irq_b, m_p_irq_b;
    logic [7:0] m_p_rd;

    function automatic logic avail(int occ);
        return m_v ? (occ >= TH) : (occ >= 1);
    endfunction

    function automatic logic [7:0] stat(logic a, logic nf, logic o);
        return {a, nf, o, 2'b00, m_v, m_i, m_q};
    endfunction

    task automatic model_reset();
        hp_q.delete(); ph_q.delete(); exp_h_q.delete(); exp_p_q.delete();
        m_q = 0; m_i = 0; m_v = 0; m_ovf_hp = 0; m_ovf_ph = 0;
        m_h_irq_b = 1; m_p_irq_b = 1; m_p_rd = 8'h00;
    endtask

    // One clock with both sides driving; expected reads go to the
    // scoreboard before the edge, the model advances after it.
    task automatic step(input logic hcs, input logic hwe, input logic haddr, input logic [7:0] hwd,
                        input logic pcs, input logic pwe, input logic paddr, input logic [7:0] pwd);
        logic hpush, hctl, ppush, ppop, nh, np;
        logic [7:0] e;
        h_cs = hcs; h_we = hwe; h_addr = haddr; h_wdata = hwd;
        p_cs = pcs; p_we = pwe; p_addr = paddr; p_wdata = pwd;
        hpush = hcs & hwe & haddr;
        hctl  = hcs & hwe & ~haddr;
        ppush = pcs & pwe & paddr;
        ppop  = pcs & ~pwe & paddr;
        if (hcs && !hwe) begin
            e = haddr ? ((ph_q.size() == 0) ? 8'hFF : ph_q[0])
                      : stat(avail(ph_q.size()), ph_q.size() < D, m_ovf_hp);
            exp_h_q.push_back(e);
        end
        if (pcs && !pwe) begin
            e = paddr ? ((hp_q.size() == 0) ? 8'hFF : hp_q[0])
                      : stat(avail(hp_q.size()), hp_q.size() < D, m_ovf_ph);
            exp_p_q.push_back(e);
            m_p_rd = e;
        end
        nh = !(m_q && avail(ph_q.size()));
        np = !(m_i && avail(hp_q.size()));
        @(posedge h_phi2);
        #1;
        m_h_irq_b = nh;
        m_p_irq_b = np;
        if (hctl && hwd[3]) begin
            hp_q.delete(); ph_q.delete();
            m_ovf_hp = 0; m_ovf_ph = 0;
        end else begin
            if (hctl && hwd[4] && !hwd[7]) begin
                m_ovf_hp = 0; m_ovf_ph = 0;
            end
            if (ppop && hp_q.size() > 0) void'(hp_q.pop_front());
            if (hpush) begin
                if (hp_q.size() < D) hp_q.push_back(hwd);
                else m_ovf_hp = 1;
            end
            if (hcs && !hwe && haddr && ph_q.size() > 0) void'(ph_q.pop_front());
            if (ppush) begin
                if (ph_q.size() < D) ph_q.push_back(pwd);
                else m_ovf_ph = 1;
            end
        end
        if (hctl) begin
            if (hwd[0]) m_q = hwd[7];
            if (hwd[1]) m_i = hwd[7];
            if (hwd[2]) m_v = hwd[7];
        end
        h_cs = 0; p_cs = 0;
    endtask

    task automatic h_wr(input logic a, input logic [7:0] d); step(1, 1, a, d, 0, 0, 0, 0); endtask
    task automatic h_rd(input logic a);                      step(1, 0, a, 0, 0, 0, 0, 0); endtask
    task automatic p_wr(input logic [7:0] d);                step(0, 0, 0, 0, 1, 1, 1, d); endtask
    task automatic p_rd(input logic a);                      step(0, 0, 0, 0, 1, 0, a, 0); endtask
    task automatic idle();                                   step(0, 0, 0, 0, 0, 0, 0, 0); endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [7:0] e;
        h_wr(0, 8'h87);          // Q=I=V=1
        h_wr(1, 8'hAA);
        h_wr(1, 8'hBB);
        idle();
        idle();
        n_cmp++;
        if (p_irq_b !== 1'b0) begin
            n_bad++; $display("FAIL reset_pre_pirq: got %b exp 0", p_irq_b);
        end
        p_rd(1);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== e) begin
            n_bad++; $display("FAIL reset_pre_pread: got %h exp %h", p_rdata, e);
        end
        // Reset edge with concurrent push, pop and T write in flight.
        h_rst_b = 0;
        h_cs = 1; h_we = 1; h_addr = 1; h_wdata = 8'hCC;
        p_cs = 1; p_we = 0; p_addr = 1;
        @(posedge h_phi2);
        #1;
        h_rst_b = 1; h_cs = 0; p_cs = 0;
        model_reset();
        n_cmp++;
        if (h_rdata !== 8'h00) begin n_bad++; $display("FAIL reset_hrdata: got %h exp 00", h_rdata); end
        n_cmp++;
        if (p_rdata !== 8'h00) begin n_bad++; $display("FAIL reset_prdata: got %h exp 00", p_rdata); end
        n_cmp++;
        if (h_irq_b !== 1'b1) begin n_bad++; $display("FAIL reset_hirq: got %b exp 1", h_irq_b); end
        n_cmp++;
        if (p_irq_b !== 1'b1) begin n_bad++; $display("FAIL reset_pirq: got %b exp 1", p_irq_b); end
        h_rd(0);
        e = exp_h_q.pop_front();
        n_cmp++;
        if (h_rdata !== 8'h40 || e !== 8'h40) begin
            n_bad++; $display("FAIL reset_hstat: got %h exp 40", h_rdata);
        end
        p_rd(1);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== 8'hFF) begin n_bad++; $display("FAIL reset_hp_empty: got %h exp ff", p_rdata); end
    endtask

    task automatic test_basic();
        logic [7:0] e;
        logic [7:0] words [3];
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
        for (int i = 0; i < 3; i++) h_wr(1, words[i]);
        for (int i = 0; i < 3; i++) begin
            p_rd(1);
            e = exp_p_q.pop_front();
            n_cmp++;
            if (p_rdata !== e || p_rdata !== words[i]) begin
                n_bad++; $display("FAIL basic_pop%0d: got %h exp %h", i, p_rdata, words[i]);
            end
        end
        p_rd(0);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== e || p_rdata[7] !== 1'b0) begin
            n_bad++; $display("FAIL basic_pstat: got %h exp %h", p_rdata, e);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] e;
        for (int i = 1; i <= 5; i++) p_wr(8'hA0 + 8'(i));
        h_rd(0);
        e = exp_h_q.pop_front();
        n_cmp++;
        if (h_rdata !== 8'h80) begin n_bad++; $display("FAIL ovf_hstat: got %h exp 80 (model %h)", h_rdata, e); end
        p_rd(0);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== 8'h60) begin n_bad++; $display("FAIL ovf_pstat: got %h exp 60 (model %h)", p_rdata, e); end
        h_wr(0, 8'h10);
        p_rd(0);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== 8'h40) begin n_bad++; $display("FAIL ovf_clear: got %h exp 40", p_rdata); end
        for (int i = 0; i < 5; i++) begin
            h_rd(1);
            e = exp_h_q.pop_front();
            n_cmp++;
            if (h_rdata !== e) begin n_bad++; $display("FAIL ovf_drain%0d: got %h exp %h", i, h_rdata, e); end
        end
    endtask

    task automatic test_thresh();
        logic [7:0] e;
        h_wr(0, 8'h84);          // V=1
        h_wr(0, 8'h81);          // Q=1
        p_wr(8'hC1);
        idle();
        n_cmp++;
        if (h_irq_b !== 1'b1) begin n_bad++; $display("FAIL thr_one_word: got %b exp 1", h_irq_b); end
        p_wr(8'hC2);
        n_cmp++;
        if (h_irq_b !== 1'b1) begin n_bad++; $display("FAIL thr_same_edge: got %b exp 1", h_irq_b); end
        idle();
        n_cmp++;
        if (h_irq_b !== 1'b0) begin n_bad++; $display("FAIL thr_two_words: got %b exp 0", h_irq_b); end
        h_rd(0);
        e = exp_h_q.pop_front();
        n_cmp++;
        if (h_rdata !== 8'hC5) begin n_bad++; $display("FAIL thr_hstat: got %h exp c5 (model %h)", h_rdata, e); end
        for (int i = 0; i < 2; i++) begin
            h_rd(1);
            e = exp_h_q.pop_front();
            n_cmp++;
            if (h_rdata !== e) begin n_bad++; $display("FAIL thr_pop%0d: got %h exp %h", i, h_rdata, e); end
        end
        idle();
        n_cmp++;
        if (h_irq_b !== 1'b1) begin n_bad++; $display("FAIL thr_drained: got %b exp 1", h_irq_b); end
        h_wr(0, 8'h05);          // Q=V=0
    endtask

    task automatic test_full_pushpop();
        logic [7:0] e;
        for (int i = 1; i <= 4; i++) h_wr(1, 8'h60 + 8'(i));
        step(1, 1, 1, 8'h55, 1, 0, 1, 8'h00);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== 8'h61) begin n_bad++; $display("FAIL full_pp_read: got %h exp 61 (model %h)", p_rdata, e); end
        p_rd(0);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== 8'h80) begin n_bad++; $display("FAIL full_pp_pstat: got %h exp 80", p_rdata); end
        h_rd(0);
        e = exp_h_q.pop_front();
        n_cmp++;
        if (h_rdata !== 8'h40) begin n_bad++; $display("FAIL full_pp_no_ovf: got %h exp 40", h_rdata); end
        for (int i = 0; i < 4; i++) begin
            p_rd(1);
            e = exp_p_q.pop_front();
            n_cmp++;
            if (p_rdata !== e) begin n_bad++; $display("FAIL full_pp_drain%0d: got %h exp %h", i, p_rdata, e); end
        end
        n_cmp++;
        if (p_rdata !== 8'h55) begin n_bad++; $display("FAIL full_pp_last: got %h exp 55", p_rdata); end
    endtask

    task automatic test_empty_pop();
        logic [7:0] e;
        p_rd(1);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== 8'hFF) begin n_bad++; $display("FAIL empty_pop: got %h exp ff", p_rdata); end
        p_rd(0);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== 8'h40) begin n_bad++; $display("FAIL empty_pstat: got %h exp 40", p_rdata); end
        step(1, 1, 1, 8'h77, 1, 0, 1, 8'h00);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== 8'hFF) begin n_bad++; $display("FAIL empty_pp_read: got %h exp ff", p_rdata); end
        p_rd(1);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== 8'h77) begin n_bad++; $display("FAIL empty_pp_push: got %h exp 77", p_rdata); end
    endtask

    task automatic test_flush();
        logic [7:0] e;
        h_wr(0, 8'h82);          // I=1
        for (int i = 1; i <= 3; i++) h_wr(1, 8'hD0 + 8'(i));
        idle();
        n_cmp++;
        if (p_irq_b !== 1'b0) begin n_bad++; $display("FAIL flush_pre_pirq: got %b exp 0", p_irq_b); end
        step(1, 1, 0, 8'h08, 1, 1, 1, 8'hE1);   // T with same-edge parasite push
        idle();
        n_cmp++;
        if (p_irq_b !== 1'b1) begin n_bad++; $display("FAIL flush_pirq: got %b exp 1", p_irq_b); end
        h_rd(0);
        e = exp_h_q.pop_front();
        n_cmp++;
        if (h_rdata !== 8'h42) begin n_bad++; $display("FAIL flush_hstat: got %h exp 42 (model %h)", h_rdata, e); end
        p_rd(1);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== 8'hFF) begin n_bad++; $display("FAIL flush_hp_empty: got %h exp ff", p_rdata); end
        h_rd(1);
        e = exp_h_q.pop_front();
        n_cmp++;
        if (h_rdata !== 8'hFF) begin n_bad++; $display("FAIL flush_ph_empty: got %h exp ff", h_rdata); end
        h_wr(0, 8'h02);          // I=0
    endtask

    task automatic test_cs_low();
        logic [7:0] e;
        h_wr(1, 8'h99);
        step(0, 0, 1, 8'h00, 0, 0, 1, 8'h00);   // deselected reads
        n_cmp++;
        if (p_rdata !== m_p_rd) begin n_bad++; $display("FAIL cs_low_hold: got %h exp %h", p_rdata, m_p_rd); end
        step(0, 1, 0, 8'h87, 0, 1, 1, 8'h5A);   // deselected writes
        step(0, 1, 1, 8'h3C, 0, 1, 0, 8'h87);
        p_wr(8'h00);
        step(0, 0, 0, 8'h00, 1, 1, 0, 8'h87);   // parasite control write: ignored
        h_rd(0);
        e = exp_h_q.pop_front();
        n_cmp++;
        if (h_rdata !== 8'hC0) begin n_bad++; $display("FAIL cs_low_hstat: got %h exp c0 (model %h)", h_rdata, e); end
        p_rd(1);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== 8'h99) begin n_bad++; $display("FAIL cs_low_pop: got %h exp 99", p_rdata); end
        p_rd(1);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== 8'hFF) begin n_bad++; $display("FAIL cs_low_nopush: got %h exp ff", p_rdata); end
        h_rd(1);
        e = exp_h_q.pop_front();
        n_cmp++;
        if (h_rdata !== e) begin n_bad++; $display("FAIL cs_low_ph: got %h exp %h", h_rdata, e); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        int hop, pop_sel;
        for (int i = 0; i < 80; i++) begin
            hop     = $urandom_range(0, 2);   // 0 idle, 1 push HP, 2 pop PH
            pop_sel = $urandom_range(0, 2);   // 0 idle, 1 push PH, 2 pop HP
            step(hop != 0, hop == 1, 1, 8'($urandom), pop_sel != 0, pop_sel == 1, 1, 8'($urandom));
            if (hop == 2) begin
                e = exp_h_q.pop_front();
                n_cmp++;
                if (h_rdata !== e) begin n_bad++; $display("FAIL b2b_h%0d: got %h exp %h", i, h_rdata, e); end
            end
            if (pop_sel == 2) begin
                e = exp_p_q.pop_front();
                n_cmp++;
                if (p_rdata !== e) begin n_bad++; $display("FAIL b2b_p%0d: got %h exp %h", i, p_rdata, e); end
            end
        end
        h_rd(0);
        e = exp_h_q.pop_front();
        n_cmp++;
        if (h_rdata !== e) begin n_bad++; $display("FAIL b2b_hstat: got %h exp %h", h_rdata, e); end
        p_rd(0);
        e = exp_p_q.pop_front();
        n_cmp++;
        if (p_rdata !== e) begin n_bad++; $display("FAIL b2b_pstat: got %h exp %h", p_rdata, e); end
        n_cmp++;
        if (h_irq_b !== m_h_irq_b || p_irq_b !== m_p_irq_b) begin
            n_bad++; $display("FAIL b2b_irq: got %b%b exp %b%b", h_irq_b, p_irq_b, m_h_irq_b, m_p_irq_b);
        end
    endtask

    initial begin
        model_reset();
        h_rst_b = 0;
        repeat (2) @(posedge h_phi2);
        #1;
        h_rst_b = 1;
        test_reset();
        test_basic();
        test_overflow();
        test_thresh();
        test_full_pushpop();
        test_empty_pop();
        test_flush();
        test_cs_low();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
